// File: rtl/elink_tdc_lane_mapper_if.sv
`default_nettype none
// ============================================================================
//  Module   : elink_tdc_lane_mapper_if
//  Brief    : Configuration / readback bus of the elink-to-TDC lane mapper.
//             The master drives writes, commits and readback addresses; the
//             slave (the mapper) returns the error pulse and readback data.
//  Revision : 1.0  initial release
// ============================================================================
interface elink_tdc_lane_mapper_if #(
    parameter int SEL_W = 5
);
    logic             cfg_wr_en;
    logic [7:0]       cfg_addr;
    logic [SEL_W-1:0] cfg_data;
    logic             cfg_commit;
    logic             cfg_err;
    logic [7:0]       cfg_rd_addr;
    logic [SEL_W-1:0] cfg_rd_data;

    modport master (
        output cfg_wr_en, cfg_addr, cfg_data, cfg_commit, cfg_rd_addr,
        input  cfg_err, cfg_rd_data
    );

    modport slave (
        input  cfg_wr_en, cfg_addr, cfg_data, cfg_commit, cfg_rd_addr,
        output cfg_err, cfg_rd_data
    );
endinterface
`default_nettype wire

// File: rtl/elink_tdc_lane_mapper.sv
`default_nettype none
// ============================================================================
//  Module   : elink_tdc_lane_mapper
//  Brief    : Slices the lpGBT uplink frame into 8-bit elinks and routes any
//             elink to any TDC dline / aux output through a double-buffered
//             (shadow + active) runtime map, with a per-output stuck monitor.
//  Revision : 1.0  initial release
// ============================================================================
module elink_tdc_lane_mapper #(
    parameter int UPLINK_W  = 230,
    parameter int N_ELINK   = 28,
    parameter int TDC_COUNT = 18,
    parameter int N_AUX     = 7,
    parameter int SEL_W     = 5,
    parameter int NUM_OUT   = 2*TDC_COUNT + N_AUX
) (
    input  wire logic                   clk_40,
    input  wire logic                   rst_40,
    input  wire logic [UPLINK_W-1:0]    userDataUpLink_i,
    output logic [8*TDC_COUNT-1:0]      tdc_dline_1,
    output logic [8*TDC_COUNT-1:0]      tdc_dline_0,
    output logic [8*N_AUX-1:0]          aux_out,
    input  wire logic [15:0]            stuck_th,
    output logic [NUM_OUT-1:0]          stuck_flag,
    elink_tdc_lane_mapper_if.slave      cfg
);

    // Disabled-entry marker: all ones is always >= N_ELINK for a legal SEL_W.
    localparam logic [SEL_W-1:0] C_SEL_OFF  = '1;
    localparam logic [SEL_W:0]   C_N_ELINK  = (SEL_W+1)'(N_ELINK);
    localparam logic [7:0]       C_NUM_OUT  = 8'(NUM_OUT);
    localparam int               C_N_SRC    = 2**SEL_W;

    // Identity map for the first N_ELINK entries, remaining entries disabled.
    function automatic logic [SEL_W-1:0] f_reset_sel(input int e);
        return (e < N_ELINK) ? SEL_W'(e) : C_SEL_OFF;
    endfunction

    logic [SEL_W-1:0] r_active [NUM_OUT];
    logic [SEL_W-1:0] r_shadow [NUM_OUT];
    logic [7:0]       r_out    [NUM_OUT];
    logic [7:0]       r_prev   [NUM_OUT];
    logic [15:0]      r_cnt    [NUM_OUT];
    logic [NUM_OUT-1:0] r_flag;
    logic             r_err;
    logic [SEL_W-1:0] r_rd_data;

    logic [7:0]         w_elink_ext [C_N_SRC];
    logic [NUM_OUT-1:0] w_enabled;
    logic [NUM_OUT-1:0] w_stuck;
    logic [SEL_W-1:0]   w_rd_sel;
    logic [15:0]        w_th_m1;

    // Elink slicing; selector codes beyond N_ELINK read as zero so a disabled
    // entry needs no special case in the datapath mux.
    for (genvar i = 0; i < C_N_SRC; i++) begin : g_elink
        if (i < N_ELINK) begin : g_live
            assign w_elink_ext[i] = userDataUpLink_i[8*i +: 8];
        end else begin : g_dead
            assign w_elink_ext[i] = 8'h00;
        end
    end

    // Uplink bits above the last elink carry nothing for this block.
    if (UPLINK_W > 8*N_ELINK) begin : g_spare
        logic w_unused_bits;
        assign w_unused_bits = ^userDataUpLink_i[UPLINK_W-1:8*N_ELINK];
    end

    // Shadow takes writes; active is replaced wholesale on commit, seeing the
    // pre-write shadow when both happen in the same cycle.
    always_ff @(posedge clk_40) begin
        if (rst_40) begin
            for (int e = 0; e < NUM_OUT; e++) begin
                r_active[e] <= f_reset_sel(e);
                r_shadow[e] <= f_reset_sel(e);
            end
        end else begin
            for (int e = 0; e < NUM_OUT; e++) begin
                if (cfg.cfg_commit) begin
                    r_active[e] <= r_shadow[e];
                end
                if (cfg.cfg_wr_en && (cfg.cfg_addr == 8'(e))) begin
                    r_shadow[e] <= cfg.cfg_data;
                end
            end
        end
    end

    // Registered routing mux; previous byte kept for stuck detection.
    always_ff @(posedge clk_40) begin
        if (rst_40) begin
            for (int e = 0; e < NUM_OUT; e++) begin
                r_out[e]  <= 8'h00;
                r_prev[e] <= 8'h00;
            end
        end else begin
            for (int e = 0; e < NUM_OUT; e++) begin
                r_out[e]  <= w_elink_ext[r_active[e]];
                r_prev[e] <= r_out[e];
            end
        end
    end

    // Per-entry enable and "stuck this cycle" qualifiers.
    always_comb begin
        w_enabled = '0;
        w_stuck   = '0;
        for (int e = 0; e < NUM_OUT; e++) begin
            w_enabled[e] = ({1'b0, r_active[e]} < C_N_ELINK);
            w_stuck[e]   = ((r_out[e] == 8'h00) || (r_out[e] == 8'hFF)) &&
                           (r_out[e] == r_prev[e]);
        end
    end

    assign w_th_m1 = stuck_th - 16'd1;

    // Stuck counters: saturating run length, flag once the run reaches the threshold.
    always_ff @(posedge clk_40) begin
        for (int e = 0; e < NUM_OUT; e++) begin
            if (rst_40 || cfg.cfg_commit || (stuck_th == 16'd0) || !w_enabled[e]) begin
                r_cnt[e]  <= 16'd0;
                r_flag[e] <= 1'b0;
            end else if (w_stuck[e]) begin
                if (r_cnt[e] != 16'hFFFF) begin
                    r_cnt[e] <= r_cnt[e] + 16'd1;
                end
                if (r_cnt[e] >= w_th_m1) begin
                    r_flag[e] <= 1'b1;
                end
            end else begin
                r_cnt[e]  <= 16'd0;
                r_flag[e] <= 1'b0;
            end
        end
    end

    // Readback selector; out-of-range addresses fall through to zero.
    always_comb begin
        w_rd_sel = '0;
        for (int e = 0; e < NUM_OUT; e++) begin
            if (cfg.cfg_rd_addr == 8'(e)) begin
                w_rd_sel = r_active[e];
            end
        end
    end

    // Registered readback and one-cycle out-of-range write error pulse.
    always_ff @(posedge clk_40) begin
        if (rst_40) begin
            r_err     <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_err     <= cfg.cfg_wr_en && (cfg.cfg_addr >= C_NUM_OUT);
            r_rd_data <= w_rd_sel;
        end
    end

    for (genvar k = 0; k < TDC_COUNT; k++) begin : g_tdc
        assign tdc_dline_1[8*k +: 8] = r_out[2*k];
        assign tdc_dline_0[8*k +: 8] = r_out[2*k+1];
    end

    for (genvar a = 0; a < N_AUX; a++) begin : g_aux
        assign aux_out[8*a +: 8] = r_out[2*TDC_COUNT + a];
    end

    assign stuck_flag      = r_flag;
    assign cfg.cfg_err     = r_err;
    assign cfg.cfg_rd_data = r_rd_data;

endmodule
`default_nettype wire
